fact_ctrl: RTL and testbench
============================

Name: fact_ctrl

Overview:
- Control unit and register front-end for the factorial accelerator in the memory-mapped I/O space at 0x900.
- Takes CPU writes (qualified by the decoder's factorial write-enable) and sequences an external iterative-multiply factorial datapath.
- Exposes N, GO, STATUS and RESULT registers for the CPU to read back.
- Replaces the current loose done/result wiring with a single owned register window.

Parameters:
- DATA_W, 32, width of the CPU data bus and of the result.
- N_W, 4, width of the factorial operand N.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- we  input  1  write strobe (factorial write-enable from the address decoder)
- a  input  2  word offset, addr[3:2]: 0=N, 1=GO, 2=STATUS, 3=RESULT
- wd  input  DATA_W  CPU write data
- rd  output  DATA_W  CPU read data (combinational from a)
- dp_n  output  N_W  operand to datapath (= N register)
- dp_load_cnt  output  1  load datapath down-counter with dp_n
- dp_en_cnt  output  1  decrement datapath counter
- dp_load_reg  output  1  load datapath product register
- dp_sel  output  1  product mux: 0 = constant 1, 1 = product*count
- dp_gt  input  1  datapath counter > 1
- dp_err  input  1  dp_n > 12 (result would overflow 32 bits)
- dp_product  input  DATA_W  datapath product register
- busy  output  1  FSM not IDLE
- done  output  1  STATUS.done
- err  output  1  STATUS.err

Behaviour:

Reset (async, rst=1):
- state=IDLE; N=0, RESULT=0, done=0, err=0.
- All dp_* strobes are 0; busy=0.
- Reset mid-operation aborts the run immediately; no partial result is kept.

Register writes (sampled on the rising edge with we=1):
- a=0: N <= wd[N_W-1:0]. Ignored while busy.
- a=1: if wd[0]=1 and state=IDLE, start a run. Ignored while busy; no queuing.
- a=2, a=3: writes ignored.

Reads (combinational):
- a=0 -> {0, N}
- a=1 -> {0, busy}
- a=2 -> {0, err, done} (err at bit 1, done at bit 0)
- a=3 -> RESULT

FSM states and outputs (all outputs Moore except CALC):
- IDLE: no strobes. On GO -> CHECK; clear done and err on that same edge.
- CHECK: if dp_err -> IDLE with err<=1, RESULT unchanged; else -> LOAD.
- LOAD: dp_load_cnt=1, dp_load_reg=1, dp_sel=0 (product <= 1) -> CALC.
- CALC: if dp_gt then dp_load_reg=1, dp_sel=1, dp_en_cnt=1 and stay; else -> DONE, no strobes.
- DONE: RESULT <= dp_product, done <= 1 -> IDLE.

Latency:
- Counting edges from the GO-write edge as edge 1, done=1 and RESULT are valid after edge 5+max(N-1,0).
- N=0 or N=1: 5 edges, RESULT=1. N=5: 9 edges. N=12: 16 edges.
- Error path: err=1 after edge 2.

Persistence and corner cases:
- done and err are sticky until the next accepted GO or reset.
- RESULT holds its last value across runs, including error runs.
- The GO write and the FSM leaving DONE cannot coincide, because GO is only accepted in IDLE.
- A GO on the same edge DONE->IDLE occurs is ignored.
- An N write with a=0 while in DONE is ignored (busy=1).

Decomposition:
- Package fact_pkg:
  - state encoding typedef (IDLE, CHECK, LOAD, CALC, DONE)
  - register offset constants OFF_N=0, OFF_GO=1, OFF_STATUS=2, OFF_RESULT=3
  - FACT_MAX_N=12
- One natural sub-module, fact_fsm: the state register plus next-state and strobe logic.
- fact_ctrl keeps the register file and the read mux.

Test Plan:
- Reset, then read all four offsets -> 0, 0, 0, 0; dp_* strobes 0.
- Write N=5, GO -> busy=1 next edge; done=1 and RESULT=120 (0x78) exactly 9 edges after GO; done stays 1 until the next GO.
- N=12 -> RESULT=479001600 (0x1C8CFC00) after 16 edges. N=0 -> RESULT=1 after 5 edges. N=1 -> RESULT=1 after 5 edges.
- N=13, GO -> err=1, done=0 after 2 edges; RESULT keeps the previous value (120); a following N=3, GO clears err and yields RESULT=6.
- During an N=6 run: write N=2 and GO=1 mid-CALC -> both ignored; RESULT=720; N reads back 6.
- Start N=7, assert rst in CALC -> all outputs 0 immediately (async); after release, N=4, GO -> RESULT=24.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared definitions for the factorial accelerator front-end: FSM state
// encoding, register window offsets and the largest operand that fits.
`timescale 1ns/1ps
package fact_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    LOAD  = 3'd2,
    CALC  = 3'd3,
    DONE  = 3'd4
  } fact_state_t;

  localparam logic [1:0] OFF_N      = 2'd0;
  localparam logic [1:0] OFF_GO     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_RESULT = 2'd3;

  // 13! no longer fits in 32 bits; the datapath flags anything above this.
  localparam int FACT_MAX_N = 12;

endpackage

// File: rtl/fact_ctrl_if.sv
// CPU-side register bus for the factorial window: write strobe, word
// offset, write data and the combinational read data.
`timescale 1ns/1ps
interface fact_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              we;
  logic [1:0]        a;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd;

  modport master (output we, output a, output wd, input rd);
  modport slave  (input we, input a, input wd, output rd);
endinterface

// File: rtl/fact_fsm.sv
// Sequencer for the external iterative-multiply datapath. Produces the
// datapath strobes plus single-cycle pulses telling the register file when
// a run starts, when it fails the range check and when the result is ready.
`timescale 1ns/1ps
module fact_fsm
  import fact_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_go,
  input  logic dp_gt,
  input  logic dp_err,
  output logic o_busy,
  output logic dp_load_cnt,
  output logic dp_en_cnt,
  output logic dp_load_reg,
  output logic dp_sel,
  output logic o_start,
  output logic o_set_err,
  output logic o_set_done
);

  fact_state_t r_state;
  fact_state_t w_state_next;

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and strobe decode; only CALC looks at dp_gt for its strobes.
  always_comb begin
    w_state_next = r_state;
    dp_load_cnt  = 1'b0;
    dp_en_cnt    = 1'b0;
    dp_load_reg  = 1'b0;
    dp_sel       = 1'b0;
    o_start      = 1'b0;
    o_set_err    = 1'b0;
    o_set_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_go) begin
          w_state_next = CHECK;
          o_start      = 1'b1;
        end
      end
      CHECK: begin
        if (dp_err) begin
          w_state_next = IDLE;
          o_set_err    = 1'b1;
        end else begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        // counter <= N, product <= 1
        dp_load_cnt  = 1'b1;
        dp_load_reg  = 1'b1;
        dp_sel       = 1'b0;
        w_state_next = CALC;
      end
      CALC: begin
        if (dp_gt) begin
          dp_load_reg = 1'b1;
          dp_sel      = 1'b1;
          dp_en_cnt   = 1'b1;
        end else begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        o_set_done   = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_busy = (r_state != IDLE);

endmodule

// File: rtl/fact_ctrl.sv
// Register front-end of the factorial accelerator: owns N, RESULT and the
// sticky done/err status, decodes CPU writes and drives the read mux.
`timescale 1ns/1ps
module fact_ctrl
  import fact_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  fact_ctrl_if.slave        bus,
  output logic [N_W-1:0]    dp_n,
  output logic              dp_load_cnt,
  output logic              dp_en_cnt,
  output logic              dp_load_reg,
  output logic              dp_sel,
  input  logic              dp_gt,
  input  logic              dp_err,
  input  logic [DATA_W-1:0] dp_product,
  output logic              busy,
  output logic              done,
  output logic              err
);

  logic [N_W-1:0]    r_n;
  logic [DATA_W-1:0] r_result;
  logic              r_done;
  logic              r_err;

  logic w_busy;
  logic w_go_wr;
  logic w_n_wr;
  logic w_start;
  logic w_set_err;
  logic w_set_done;
  logic w_unused_wd;

  // A GO request is only acted on by the FSM when it is idle.
  assign w_go_wr = bus.we && (bus.a == OFF_GO) && bus.wd[0];
  // N is frozen while a run is in flight so the datapath operand is stable.
  assign w_n_wr  = bus.we && (bus.a == OFF_N) && !w_busy;

  assign w_unused_wd = ^bus.wd[DATA_W-1:N_W];

  fact_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .i_go        (w_go_wr),
    .dp_gt       (dp_gt),
    .dp_err      (dp_err),
    .o_busy      (w_busy),
    .dp_load_cnt (dp_load_cnt),
    .dp_en_cnt   (dp_en_cnt),
    .dp_load_reg (dp_load_reg),
    .dp_sel      (dp_sel),
    .o_start     (w_start),
    .o_set_err   (w_set_err),
    .o_set_done  (w_set_done)
  );

  // Operand register, writable only between runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n <= '0;
    end else if (w_n_wr) begin
      r_n <= bus.wd[N_W-1:0];
    end
  end

  // Result capture on the DONE cycle; held across error runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
    end else if (w_set_done) begin
      r_result <= dp_product;
    end
  end

  // Sticky status: cleared by an accepted GO, set by run outcome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_start) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_set_done) r_done <= 1'b1;
      if (w_set_err)  r_err  <= 1'b1;
    end
  end

  // Combinational read mux over the four-word window.
  always_comb begin
    bus.rd = '0;
    case (bus.a)
      OFF_N:      bus.rd = {{(DATA_W-N_W){1'b0}}, r_n};
      OFF_GO:     bus.rd = {{(DATA_W-1){1'b0}}, w_busy};
      OFF_STATUS: bus.rd = {{(DATA_W-2){1'b0}}, r_err, r_done};
      OFF_RESULT: bus.rd = r_result;
      default:    bus.rd = '0;
    endcase
  end

  assign dp_n = r_n;
  assign busy = w_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_fact_ctrl.sv
// Scoreboard bench for fact_ctrl with a behavioural down-counter/multiplier
// datapath. Each GO pushes the expected outcome; a monitor pops it when done
// or err rises and checks RESULT, status bits and arrival cycle.
`timescale 1ns/1ps
module tb_fact_ctrl;
  import fact_pkg::*;

  localparam int DATA_W = 32;
  localparam int N_W    = 4;

  logic              clk;
  logic              rst;
  logic [N_W-1:0]    dp_n;
  logic              dp_load_cnt, dp_en_cnt, dp_load_reg, dp_sel;
  logic              dp_gt, dp_err;
  logic [DATA_W-1:0] dp_product;
  logic              busy, done, err;

  fact_ctrl_if #(.DATA_W(DATA_W)) bus ();

  fact_ctrl #(.DATA_W(DATA_W), .N_W(N_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dp_n        (dp_n),
    .dp_load_cnt (dp_load_cnt),
    .dp_en_cnt   (dp_en_cnt),
    .dp_load_reg (dp_load_reg),
    .dp_sel      (dp_sel),
    .dp_gt       (dp_gt),
    .dp_err      (dp_err),
    .dp_product  (dp_product),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath
  logic [N_W-1:0]    cnt  = '0;
  logic [DATA_W-1:0] prod = '0;
  always_ff @(posedge clk) begin
    if (dp_load_cnt)    cnt <= dp_n;
    else if (dp_en_cnt) cnt <= cnt - 1'b1;
    if (dp_load_reg)    prod <= dp_sel ? prod * {{(DATA_W-N_W){1'b0}}, cnt} : 32'd1;
  end
  assign dp_gt      = (cnt > 1);
  assign dp_err     = (dp_n > FACT_MAX_N);
  assign dp_product = prod;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [31:0] result;
    logic        err;
    int          due;
    string       tag;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one line per completed run
  initial begin : monitor
    logic pd, pe, ev;
    exp_t e;
    pd = 1'b0;
    pe = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      ev = (done && !pd) || (err && !pe);
      pd = done;
      pe = err;
      if (ev) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_completion: done=%0b err=%0b with no run pending", done, err);
        end else begin
          e = q.pop_front();
          chk({e.tag, "_result"},  bus.rd, e.result);
          chk({e.tag, "_err"},     {31'd0, err}, {31'd0, e.err});
          chk({e.tag, "_done"},    {31'd0, done}, {31'd0, !e.err});
          chk({e.tag, "_latency"}, cyc, e.due);
          $display("run %s: result=%0d done=%0b err=%0b cycle=%0d", e.tag, bus.rd, done, err, cyc);
        end
      end
    end
  end

  // Called at a negedge; the write takes effect on the next rising edge.
  task automatic wr(input logic [1:0] off, input logic [31:0] data);
    bus.we = 1'b1;
    bus.a  = off;
    bus.wd = data;
    @(negedge clk);
    bus.we = 1'b0;
    bus.wd = '0;
    bus.a  = OFF_RESULT;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s_timeout: %0d run(s) never completed", tag, q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  // Issue N then GO, queue the expected outcome, wait for the monitor.
  task automatic run(input logic [3:0] n, input logic [31:0] res, input logic e_err,
                     input int lat, input string tag);
    wr(OFF_N, {28'd0, n});
    q.push_back('{res, e_err, cyc + lat, tag});
    bus.we = 1'b1;
    bus.a  = OFF_GO;
    bus.wd = 32'd1;
    @(negedge clk);
    bus.we = 1'b0;
    bus.wd = '0;
    bus.a  = OFF_RESULT;
    #1;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_drain(tag);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst    = 1'b1;
    bus.we = 1'b0;
    bus.a  = OFF_N;
    bus.wd = '0;
    repeat (3) @(negedge clk);

    // Reset state
    for (int i = 0; i < 4; i++) begin
      bus.a = i[1:0];
      #1;
      chk($sformatf("reset_rd%0d", i), bus.rd, 32'd0);
    end
    chk("reset_strobes", {28'd0, dp_load_cnt, dp_en_cnt, dp_load_reg, dp_sel}, 32'd0);
    chk("reset_flags", {29'd0, busy, done, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.a = OFF_RESULT;
    @(negedge clk);

    run(4'd5, 32'd120, 1'b0, 9, "n5");
    repeat (3) @(negedge clk);
    #1;
    chk("n5_done_sticky", {31'd0, done}, 32'd1);

    run(4'd13, 32'd120, 1'b1, 2, "n13_err");
    bus.a = OFF_STATUS;
    #1;
    chk("n13_status", bus.rd, 32'd2);
    bus.a = OFF_RESULT;

    run(4'd3,  32'd6,         1'b0, 7,  "n3");
    run(4'd12, 32'h1C8CFC00,  1'b0, 16, "n12");
    run(4'd0,  32'd1,         1'b0, 5,  "n0");
    run(4'd1,  32'd1,         1'b0, 5,  "n1");

    // N and GO writes during CALC must be ignored
    wr(OFF_N, 32'd6);
    q.push_back('{32'd720, 1'b0, cyc + 10, "n6_midcalc"});
    bus.we = 1'b1;
    bus.a  = OFF_GO;
    bus.wd = 32'd1;
    @(negedge clk);
    bus.we = 1'b0;
    bus.a  = OFF_RESULT;
    repeat (2) @(negedge clk);
    wr(OFF_N, 32'd2);
    wr(OFF_GO, 32'd1);
    #1;
    chk("n6_busy_midcalc", {31'd0, busy}, 32'd1);
    wait_drain("n6_midcalc");
    bus.a = OFF_N;
    #1;
    chk("n6_readback", bus.rd, 32'd6);
    bus.a = OFF_RESULT;
    @(negedge clk);

    // Asynchronous reset in the middle of CALC
    wr(OFF_N, 32'd7);
    bus.we = 1'b1;
    bus.a  = OFF_GO;
    bus.wd = 32'd1;
    @(negedge clk);
    bus.we = 1'b0;
    bus.a  = OFF_RESULT;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_flags", {29'd0, busy, done, err}, 32'd0);
    chk("abort_strobes", {28'd0, dp_load_cnt, dp_en_cnt, dp_load_reg, dp_sel}, 32'd0);
    chk("abort_result", bus.rd, 32'd0);
    chk("abort_dp_n", {28'd0, dp_n}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(4'd4, 32'd24, 1'b0, 8, "n4_after_rst");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
